// File: rtl/gate_unit_scheduler.sv
// Bit-serial scheduler sharing one combinational 1-bit gate unit between two requesters.
// Requests are granted round-robin and streamed LSB-first. Results return over a valid/ready port.
module gate_unit_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_err,
    output logic             busy,
    output logic             gu_a,
    output logic             gu_b,
    input  logic             gu_and,
    input  logic             gu_nand,
    input  logic             gu_or,
    input  logic             gu_nor,
    input  logic             gu_not,
    input  logic             gu_xor,
    input  logic             gu_xnor
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             id_q, id_d;
    logic             err_q, err_d;

    logic             grant_s;
    logic             accept_s;
    logic             gate_bit_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    function automatic logic gate_select(
        input logic [2:0] op,
        input logic       g_and,
        input logic       g_nand,
        input logic       g_or,
        input logic       g_nor,
        input logic       g_not,
        input logic       g_xor,
        input logic       g_xnor
    );
        logic r;
        r = 1'b0;
        case (op)
            3'd0:    r = g_and;
            3'd1:    r = g_nand;
            3'd2:    r = g_or;
            3'd3:    r = g_nor;
            3'd4:    r = g_not;
            3'd5:    r = g_xor;
            3'd6:    r = g_xnor;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Readies are held low during reset even though the state already reads IDLE.
    always_comb begin
        req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !grant_s;
        req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid &&  grant_s;
        accept_s   = req0_ready || req1_ready;
        sel_op_s   = grant_s ? req1_op : req0_op;
        sel_a_s    = grant_s ? req1_a  : req0_a;
        sel_b_s    = grant_s ? req1_b  : req0_b;
    end

    // Gate output selected by the latched opcode.
    always_comb begin
        gate_bit_s = gate_select(op_q, gu_and, gu_nand, gu_or, gu_nor,
                                 gu_not, gu_xor, gu_xnor);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        id_d    = id_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d   = sel_op_s;
                    a_d    = sel_a_s;
                    b_d    = sel_b_s;
                    id_d   = grant_s;
                    last_d = grant_s;
                    idx_d  = '0;
                    res_d  = '0;
                    err_d  = (sel_op_s == OP_ILLEGAL);
                    // An illegal opcode skips the serial phase entirely.
                    state_d = (sel_op_s == OP_ILLEGAL) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[idx_q] = gate_bit_s;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        resp_valid = (state_q == ST_DONE);
        resp_data  = res_q;
        resp_id    = id_q;
        resp_err   = err_q;
        busy       = (state_q != ST_IDLE);
        if (state_q == ST_RUN) begin
            gu_a = a_q[idx_q];
            gu_b = b_q[idx_q];
        end else begin
            gu_a = 1'b0;
            gu_b = 1'b0;
        end
    end

endmodule
